// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, op encoding, default widths.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned STREAK_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } mem_op_t;

  // Both strobes together is not a usable op; it decodes to OP_NONE.
  function automatic mem_op_t decode_op(input logic rd, input logic wr);
    mem_op_t op;
    op = OP_NONE;
    if (rd && !wr) op = OP_RD;
    if (wr && !rd) op = OP_WR;
    return op;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side (fetch/data) and memory-side signals of the arbiter, bundled as one interface.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              i_rd;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic [DATA_W-1:0] i_data;
  logic              i_done;
  logic              i_stall;

  logic              d_rd;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              d_stall;

  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_rd;
  logic              m_wr;
  logic [DATA_W-1:0] m_rdata;
  logic              m_done;
  logic              m_stall;

  logic              err;

  modport slave (
    input  i_rd, i_addr, i_flush, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_done, m_stall,
    output i_data, i_done, i_stall, d_rdata, d_done, d_stall, m_addr, m_wdata, m_rd, m_wr, err
  );

  modport master (
    output i_rd, i_addr, i_flush, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_done, m_stall,
    input  i_data, i_done, i_stall, d_rdata, d_done, d_stall, m_addr, m_wdata, m_rd, m_wr, err
  );

endinterface

// File: rtl/arb_streak_ctr.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_streak_ctr #(
  parameter int unsigned W     = 4,
  parameter int unsigned LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_limit
);

  logic [W-1:0] count_d;

  always_comb begin
    count_d = count;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count_d = count + W'(1);
    end
  end

  // Limit flag is precomputed from the next count so it is a clean register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      at_limit <= 1'b0;
    end else begin
      count    <= count_d;
      at_limit <= (count_d == W'(LIMIT));
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory between the fetch and data ports: data has priority,
// a streak counter prevents fetch starvation, and a redirect squashes an in-flight fetch.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  arb_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                squash_q, squash_d;
  logic                err_q, err_d;

  logic                streak_inc, streak_clr, streak_limit;
  logic [STREAK_W-1:0] streak;

  mem_op_t             d_op;
  logic                d_valid, d_illegal, grant_i, grant_d;
  logic                i_done_c, d_done_c;
  logic                unused_ok;

  assign d_op      = decode_op(bus.d_rd, bus.d_wr);
  assign d_valid   = (d_op != OP_NONE);
  assign d_illegal = bus.d_rd & bus.d_wr;
  assign grant_i   = bus.i_rd & (~d_valid | streak_limit);
  assign grant_d   = d_valid & ~grant_i;

  // Memory busy is informational only: the command is held until m_done regardless.
  assign unused_ok = &{1'b1, bus.m_stall};

  arb_streak_ctr #(
    .W     (STREAK_W),
    .LIMIT (MAX_D_STREAK)
  ) u_streak (
    .clk      (clk),
    .rst      (rst),
    .inc      (streak_inc),
    .clr      (streak_clr),
    .count    (streak),
    .at_limit (streak_limit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      squash_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      squash_q <= squash_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    squash_d   = squash_q;
    err_d      = 1'b0;
    streak_inc = 1'b0;
    streak_clr = 1'b0;

    case (state_q)
      IDLE: begin
        err_d      = d_illegal;
        streak_clr = ~bus.i_rd;
        squash_d   = 1'b0;
        if (grant_i) begin
          state_d    = BUSY_I;
          addr_d     = bus.i_addr;
          wdata_d    = '0;
          rd_d       = 1'b1;
          wr_d       = 1'b0;
          streak_clr = 1'b1;
        end else if (grant_d) begin
          state_d    = BUSY_D;
          addr_d     = bus.d_addr;
          wdata_d    = bus.d_wdata;
          rd_d       = (d_op == OP_RD);
          wr_d       = (d_op == OP_WR);
          streak_inc = bus.i_rd;
        end
      end

      BUSY_I: begin
        if (bus.m_done) begin
          state_d  = IDLE;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          squash_d = 1'b0;
        end else if (bus.i_flush) begin
          squash_d = 1'b1;
        end
      end

      BUSY_D: begin
        if (bus.m_done) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // Port completions follow m_done in the same cycle; a redirect suppresses the fetch result.
  assign i_done_c = (state_q == BUSY_I) & bus.m_done & ~squash_q & ~bus.i_flush;
  assign d_done_c = (state_q == BUSY_D) & bus.m_done;

  assign bus.i_done  = i_done_c;
  assign bus.i_data  = i_done_c ? bus.m_rdata : '0;
  assign bus.i_stall = bus.i_rd & ~i_done_c;

  assign bus.d_done  = d_done_c;
  assign bus.d_rdata = (d_done_c & rd_q) ? bus.m_rdata : '0;
  assign bus.d_stall = (bus.d_rd | bus.d_wr) & ~d_done_c;

  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.m_rd    = rd_q;
  assign bus.m_wr    = wr_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch latency, contention, starvation guard, squash, illegal op, reset.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (16),
    .MAX_D_STREAK (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.i_rd    = 1'b0;
    bus.i_addr  = '0;
    bus.i_flush = 1'b0;
    bus.d_rd    = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_rdata = '0;
    bus.m_done  = 1'b0;
    bus.m_stall = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst      = 1'b0;
    bus.i_rd = 1'b1;
    #2;
    check("rst_m_rd",    32'(bus.m_rd),    32'd0);
    check("rst_m_wr",    32'(bus.m_wr),    32'd0);
    check("rst_m_addr",  32'(bus.m_addr),  32'd0);
    check("rst_err",     32'(bus.err),     32'd0);
    check("rst_i_done",  32'(bus.i_done),  32'd0);
    check("rst_i_stall", 32'(bus.i_stall), 32'd1);
    check("rst_streak",  32'(dut.streak),  32'd0);
    bus.i_rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Single fetch, memory latency 3
    next_cyc(); bus.i_rd = 1'b1; bus.i_addr = 16'h0010; sample();
    check("f_c0_stall", 32'(bus.i_stall), 32'd1);
    check("f_c0_mrd",   32'(bus.m_rd),    32'd0);
    for (int c = 1; c <= 3; c++) begin
      next_cyc();
      if (c == 3) begin bus.m_done = 1'b1; bus.m_rdata = 16'h1234; end
      sample();
      check("f_mrd",   32'(bus.m_rd),    32'd1);
      check("f_maddr", 32'(bus.m_addr),  32'h0010);
      check("f_done",  32'(bus.i_done),  32'(c == 3));
      check("f_stall", 32'(bus.i_stall), 32'(c != 3));
      check("f_data",  32'(bus.i_data),  (c == 3) ? 32'h1234 : 32'h0);
    end
    next_cyc(); bus.m_done = 1'b0; bus.i_rd = 1'b0; sample();
    check("f_end_mrd",  32'(bus.m_rd),   32'd0);
    check("f_end_data", 32'(bus.i_data), 32'd0);

    // Contention: data write wins, then fetch after one idle cycle
    next_cyc();
    bus.i_rd = 1'b1; bus.i_addr = 16'h0020;
    bus.d_wr = 1'b1; bus.d_addr = 16'h0100; bus.d_wdata = 16'hBEEF;
    sample();
    check("c_c0_dstall", 32'(bus.d_stall), 32'd1);
    check("c_c0_mwr",    32'(bus.m_wr),    32'd0);
    next_cyc(); bus.m_done = 1'b1; bus.m_rdata = 16'h5555; sample();
    check("c_mwr",    32'(bus.m_wr),    32'd1);
    check("c_mrd",    32'(bus.m_rd),    32'd0);
    check("c_maddr",  32'(bus.m_addr),  32'h0100);
    check("c_mwdata", 32'(bus.m_wdata), 32'hBEEF);
    check("c_ddone",  32'(bus.d_done),  32'd1);
    check("c_drdata", 32'(bus.d_rdata), 32'd0);
    check("c_idone",  32'(bus.i_done),  32'd0);
    check("c_istall", 32'(bus.i_stall), 32'd1);
    check("c_streak", 32'(dut.streak),  32'd1);
    next_cyc(); bus.m_done = 1'b0; bus.d_wr = 1'b0; sample();
    check("c_gap_mwr", 32'(bus.m_wr), 32'd0);
    check("c_gap_mrd", 32'(bus.m_rd), 32'd0);
    next_cyc(); bus.m_done = 1'b1; bus.m_rdata = 16'hCAFE; sample();
    check("c_i_maddr",  32'(bus.m_addr), 32'h0020);
    check("c_i_done",   32'(bus.i_done), 32'd1);
    check("c_i_data",   32'(bus.i_data), 32'hCAFE);
    check("c_i_streak", 32'(dut.streak), 32'd0);
    next_cyc(); bus.m_done = 1'b0; bus.i_rd = 1'b0; sample();
    check("c_end_mrd", 32'(bus.m_rd), 32'd0);

    // Starvation guard: four data grants, then the fetch
    next_cyc();
    bus.d_rd = 1'b1; bus.d_addr = 16'h0200; bus.m_rdata = 16'h00D0;
    bus.i_rd = 1'b1; bus.i_addr = 16'h0030;
    for (int k = 0; k < 4; k++) begin
      sample();
      check("s_idle_mrd", 32'(bus.m_rd),   32'd0);
      check("s_pre",      32'(dut.streak), 32'(k));
      next_cyc(); bus.m_done = 1'b1; sample();
      check("s_d_addr",  32'(bus.m_addr),  32'h0200);
      check("s_d_done",  32'(bus.d_done),  32'd1);
      check("s_d_rdata", 32'(bus.d_rdata), 32'h00D0);
      check("s_i_stall", 32'(bus.i_stall), 32'd1);
      check("s_streak",  32'(dut.streak),  32'(k + 1));
      next_cyc(); bus.m_done = 1'b0;
    end
    sample();
    check("s_limit", 32'(dut.streak), 32'd4);
    next_cyc(); bus.m_done = 1'b1; bus.m_rdata = 16'h0C0D; sample();
    check("s_i_maddr",  32'(bus.m_addr),  32'h0030);
    check("s_i_done",   32'(bus.i_done),  32'd1);
    check("s_i_data",   32'(bus.i_data),  32'h0C0D);
    check("s_d_wait",   32'(bus.d_stall), 32'd1);
    check("s_i_streak", 32'(dut.streak),  32'd0);
    next_cyc(); bus.m_done = 1'b0; bus.i_rd = 1'b0; sample();
    check("s_tail_idle", 32'(bus.m_rd), 32'd0);
    next_cyc(); bus.m_done = 1'b1; sample();
    check("s_tail_done",   32'(bus.d_done), 32'd1);
    check("s_tail_streak", 32'(dut.streak), 32'd0);
    next_cyc(); bus.m_done = 1'b0; bus.d_rd = 1'b0;

    // Flush in cycle 2 of a 4-cycle fetch
    next_cyc(); bus.i_rd = 1'b1; bus.i_addr = 16'h0040; sample();
    next_cyc(); sample();
    check("q_c1_mrd", 32'(bus.m_rd), 32'd1);
    next_cyc(); bus.i_flush = 1'b1; sample();
    check("q_c2_stall", 32'(bus.i_stall), 32'd1);
    check("q_c2_done",  32'(bus.i_done),  32'd0);
    next_cyc(); bus.i_flush = 1'b0; sample();
    check("q_c3_squash", 32'(dut.squash_q), 32'd1);
    check("q_c3_mrd",    32'(bus.m_rd),     32'd1);
    next_cyc(); bus.m_done = 1'b1; bus.m_rdata = 16'h7777; sample();
    check("q_c4_mrd",  32'(bus.m_rd),   32'd1);
    check("q_c4_done", 32'(bus.i_done), 32'd0);
    check("q_c4_data", 32'(bus.i_data), 32'd0);
    next_cyc(); bus.m_done = 1'b0; bus.i_addr = 16'h0044; sample();
    check("q_c5_mrd",    32'(bus.m_rd),     32'd0);
    check("q_c5_squash", 32'(dut.squash_q), 32'd0);
    next_cyc(); bus.m_done = 1'b1; bus.m_rdata = 16'h4444; sample();
    check("q_next_addr", 32'(bus.m_addr), 32'h0044);
    check("q_next_done", 32'(bus.i_done), 32'd1);
    check("q_next_data", 32'(bus.i_data), 32'h4444);
    next_cyc(); bus.m_done = 1'b0; bus.i_rd = 1'b0;

    // Flush in the same cycle as m_done
    next_cyc(); bus.i_rd = 1'b1; bus.i_addr = 16'h0048; sample();
    next_cyc(); bus.m_done = 1'b1; bus.i_flush = 1'b1; bus.m_rdata = 16'h4848; sample();
    check("qs_mrd",  32'(bus.m_rd),   32'd1);
    check("qs_done", 32'(bus.i_done), 32'd0);
    check("qs_data", 32'(bus.i_data), 32'd0);
    next_cyc(); bus.m_done = 1'b0; bus.i_flush = 1'b0; bus.i_rd = 1'b0; sample();
    check("qs_end_mrd", 32'(bus.m_rd), 32'd0);

    // m_done while idle is ignored
    next_cyc(); bus.m_done = 1'b1; sample();
    check("x_idone", 32'(bus.i_done), 32'd0);
    check("x_ddone", 32'(bus.d_done), 32'd0);
    next_cyc(); bus.m_done = 1'b0; sample();
    check("x_mrd",   32'(bus.m_rd),    32'd0);
    check("x_state", 32'(dut.state_q), 32'(IDLE));

    // Illegal data request alone
    next_cyc(); bus.d_rd = 1'b1; bus.d_wr = 1'b1; sample();
    check("e_c0_err",   32'(bus.err),     32'd0);
    check("e_c0_stall", 32'(bus.d_stall), 32'd1);
    next_cyc(); bus.d_rd = 1'b0; bus.d_wr = 1'b0; sample();
    check("e_c1_err", 32'(bus.err),  32'd1);
    check("e_c1_mrd", 32'(bus.m_rd), 32'd0);
    check("e_c1_mwr", 32'(bus.m_wr), 32'd0);
    next_cyc(); sample();
    check("e_c2_err", 32'(bus.err), 32'd0);

    // Illegal data request alongside a fetch: fetch still granted
    next_cyc();
    bus.d_rd = 1'b1; bus.d_wr = 1'b1; bus.i_rd = 1'b1; bus.i_addr = 16'h0050;
    sample();
    next_cyc();
    bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.m_done = 1'b1; bus.m_rdata = 16'h5050;
    sample();
    check("ef_err",   32'(bus.err),    32'd1);
    check("ef_mrd",   32'(bus.m_rd),   32'd1);
    check("ef_mwr",   32'(bus.m_wr),   32'd0);
    check("ef_maddr", 32'(bus.m_addr), 32'h0050);
    check("ef_data",  32'(bus.i_data), 32'h5050);
    next_cyc(); bus.m_done = 1'b0; bus.i_rd = 1'b0; sample();
    check("ef_err_end", 32'(bus.err), 32'd0);

    // Reset asserted in the middle of a data write
    next_cyc(); bus.d_wr = 1'b1; bus.d_addr = 16'h0060; bus.d_wdata = 16'h1111; sample();
    next_cyc(); sample();
    check("r_mwr_busy", 32'(bus.m_wr), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("r_mwr",    32'(bus.m_wr),    32'd0);
    check("r_maddr",  32'(bus.m_addr),  32'd0);
    check("r_mwdata", 32'(bus.m_wdata), 32'd0);
    check("r_state",  32'(dut.state_q), 32'(IDLE));
    check("r_dstall", 32'(bus.d_stall), 32'd1);
    check("r_ddone",  32'(bus.d_done),  32'd0);
    bus.d_wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    next_cyc(); sample();
    check("r_after_mwr", 32'(bus.m_wr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
